// File: rtl/f1_start_seq.sv
// F1 start-light sequencer: tick divider, LFSR random hold and (optionally) reaction timing.
// Reaction timing (REACT state, rt, rt_valid, false_start) is built only when F1_REACT_TIMER_EN is defined.
module f1_start_seq #(
  parameter int NLIGHTS = 8,
  parameter int WIDTH   = 8,
  parameter int LFSR_W  = 7,
  parameter int RT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [WIDTH-1:0]   N,
  input  logic               trigger,
  input  logic               react,
  output logic [NLIGHTS-1:0] dout,
  output logic               cmd_seq,
  output logic               cmd_delay,
  output logic [LFSR_W-1:0]  delay_n,
  output logic [RT_W-1:0]    rt,
  output logic               rt_valid,
  output logic               false_start,
  output logic [1:0]         state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEQ   = 2'd1,
    S_DELAY = 2'd2,
    S_REACT = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0]  DIV_ONE = WIDTH'(1);
  localparam logic [LFSR_W-1:0] HC_ONE  = LFSR_W'(1);

  state_t              state_q, state_d;
  logic                trig_q;
  logic [LFSR_W-1:0]   lfsr_q, lfsr_d;
  logic                lfsr_fb;
  logic [WIDTH-1:0]    div_q, div_d;
  logic [NLIGHTS-1:0]  dout_q, dout_d;
  logic [LFSR_W-1:0]   hc_q, hc_d;
  logic [RT_W-1:0]     rc_q, rc_d;
  logic [RT_W-1:0]     rt_q, rt_d;
  logic                rt_valid_q, rt_valid_d;
  logic                false_start_q, false_start_d;
  logic                trig_edge;
  logic                tick;
  logic                early_press;

  generate
    if (LFSR_W == 4) begin : g_tap4
      assign lfsr_fb = lfsr_q[3] ^ lfsr_q[2];
    end else if (LFSR_W == 8) begin : g_tap8
      assign lfsr_fb = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
    end else begin : g_tap7
      assign lfsr_fb = lfsr_q[LFSR_W-1] ^ lfsr_q[LFSR_W-2];
    end
  endgenerate

  // The LFSR free-runs on en in every state so the hold length depends on when the start happens.
  assign lfsr_d    = en ? {lfsr_q[LFSR_W-2:0], lfsr_fb} : lfsr_q;
  assign trig_edge = trigger & ~trig_q;
  assign tick      = (div_q == '0);

`ifdef F1_REACT_TIMER_EN
  localparam logic [RT_W-1:0] RC_ONE = RT_W'(1);
  localparam logic [RT_W-1:0] RC_MAX = '1;
  assign early_press = react;
`else
  assign early_press = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    dout_d        = dout_q;
    div_d         = div_q;
    hc_d          = hc_q;
    rc_d          = rc_q;
    rt_d          = rt_q;
    rt_valid_d    = 1'b0;
    false_start_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (trig_edge) begin
          state_d = S_SEQ;
          dout_d  = '0;
          div_d   = N;
        end
      end
      S_SEQ: begin
        div_d = tick ? N : (div_q - DIV_ONE);
        // An early press wins over a tick landing on the same cycle.
        if (early_press) begin
          false_start_d = 1'b1;
          dout_d        = '0;
          state_d       = S_IDLE;
        end else if (tick) begin
          dout_d = {dout_q[NLIGHTS-2:0], 1'b1};
          if (dout_q[NLIGHTS-2]) begin
            state_d = S_DELAY;
            hc_d    = lfsr_q;
          end
        end
      end
      S_DELAY: begin
        div_d = tick ? N : (div_q - DIV_ONE);
        if (early_press) begin
          false_start_d = 1'b1;
          dout_d        = '0;
          state_d       = S_IDLE;
        end else if (tick) begin
          hc_d = hc_q - HC_ONE;
          if (hc_q == HC_ONE) begin
            dout_d = '0;
            rc_d   = '0;
`ifdef F1_REACT_TIMER_EN
            state_d = S_REACT;
`else
            state_d = S_IDLE;
`endif
          end
        end
      end
      S_REACT: begin
`ifdef F1_REACT_TIMER_EN
        // rt_valid is a one-cycle qualifier for rt with no back-pressure: capture rt on the pulse.
        if (react) begin
          rt_d       = rc_q;
          rt_valid_d = 1'b1;
          state_d    = S_IDLE;
        end else if (rc_q == RC_MAX) begin
          rt_d       = RC_MAX;
          rt_valid_d = 1'b1;
          state_d    = S_IDLE;
        end else begin
          rc_d = rc_q + RC_ONE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      trig_q        <= 1'b0;
      lfsr_q        <= HC_ONE;
      div_q         <= '0;
      dout_q        <= '0;
      hc_q          <= '0;
      rc_q          <= '0;
      rt_q          <= '0;
      rt_valid_q    <= 1'b0;
      false_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      trig_q        <= trigger;
      lfsr_q        <= lfsr_d;
      div_q         <= div_d;
      dout_q        <= dout_d;
      hc_q          <= hc_d;
      rc_q          <= rc_d;
      rt_q          <= rt_d;
      rt_valid_q    <= rt_valid_d;
      false_start_q <= false_start_d;
    end
  end

  assign dout      = dout_q;
  assign cmd_seq   = (state_q == S_SEQ);
  assign cmd_delay = (state_q == S_DELAY);
  assign delay_n   = lfsr_q;
  assign state_o   = state_q;

`ifdef F1_REACT_TIMER_EN
  assign rt          = rt_q;
  assign rt_valid    = rt_valid_q;
  assign false_start = false_start_q;
`else
  assign rt          = '0;
  assign rt_valid    = 1'b0;
  assign false_start = 1'b0;
  logic unused_react_path;
  assign unused_react_path = ^{react, rt_q, rt_valid_q, false_start_q, rc_q};
`endif

endmodule

// File: tb/tb_f1_start_seq.sv
// Bench for f1_start_seq: directed scenarios plus a cycle-by-cycle comparison against a phase/elapsed-time model.
module tb_f1_start_seq;

  localparam int NL    = 8;
  localparam int W     = 8;
  localparam int LW    = 7;
  localparam int RW    = 16;
  localparam int RTMAX = (1 << RW) - 1;
`ifdef F1_REACT_TIMER_EN
  localparam bit REACT_EN = 1'b1;
`else
  localparam bit REACT_EN = 1'b0;
`endif

  localparam int P_IDLE  = 0;
  localparam int P_SEQ   = 1;
  localparam int P_DELAY = 2;
  localparam int P_REACT = 3;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          trigger = 1'b0;
  logic          react = 1'b0;
  logic [W-1:0]  n_in = 8'd3;
  logic [NL-1:0] dout;
  logic          cmd_seq;
  logic          cmd_delay;
  logic [LW-1:0] delay_n;
  logic [RW-1:0] rt;
  logic          rt_valid;
  logic          false_start;
  logic [1:0]    state_o;

  always #5 clk = ~clk;

  f1_start_seq #(.NLIGHTS(NL), .WIDTH(W), .LFSR_W(LW), .RT_W(RW)) dut (
    .clk(clk), .rst(rst), .en(en), .N(n_in), .trigger(trigger), .react(react),
    .dout(dout), .cmd_seq(cmd_seq), .cmd_delay(cmd_delay), .delay_n(delay_n),
    .rt(rt), .rt_valid(rt_valid), .false_start(false_start), .state_o(state_o)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [NL-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Tracks which phase the light show is in and how many cycles it has spent there.
  int m_phase = P_IDLE;
  int m_el = 0;
  int m_hold = 0;
  int m_lfsr = 1;
  int m_rt = 0;
  bit m_rtv = 0;
  bit m_fs = 0;
  bit m_trig_prev = 0;
  bit m_valid = 0;

  function automatic int lfsr_next(input int v);
    int fb;
    fb = ((v >> 6) ^ (v >> 5)) & 1;
    return ((v << 1) | fb) & ((1 << LW) - 1);
  endfunction

  function automatic int exp_dout();
    int per;
    per = int'(n_in) + 1;
    if (m_phase == P_SEQ) return (1 << (m_el / per)) - 1;
    if (m_phase == P_DELAY) return (1 << NL) - 1;
    return 0;
  endfunction

  task automatic model_step();
    int per;
    int nxt;
    per   = int'(n_in) + 1;
    m_rtv = 0;
    m_fs  = 0;
    if (rst) begin
      m_phase = P_IDLE; m_el = 0; m_lfsr = 1; m_trig_prev = 0;
      m_rt = 0; m_hold = 0; m_valid = 1;
      return;
    end
    nxt = en ? lfsr_next(m_lfsr) : m_lfsr;
    case (m_phase)
      P_IDLE: begin
        if (trigger && !m_trig_prev) begin m_phase = P_SEQ; m_el = 0; end
      end
      P_SEQ: begin
        if (REACT_EN && react) begin m_fs = 1; m_phase = P_IDLE; end
        else begin
          m_el++;
          if (m_el == NL * per) begin m_phase = P_DELAY; m_hold = m_lfsr; m_el = 0; end
        end
      end
      P_DELAY: begin
        if (REACT_EN && react) begin m_fs = 1; m_phase = P_IDLE; end
        else begin
          m_el++;
          if (m_el == m_hold * per) begin
            m_phase = REACT_EN ? P_REACT : P_IDLE;
            m_el = 0;
          end
        end
      end
      default: begin
        if (react) begin m_rt = m_el; m_rtv = 1; m_phase = P_IDLE; end
        else if (m_el == RTMAX) begin m_rt = RTMAX; m_rtv = 1; m_phase = P_IDLE; end
        else m_el++;
      end
    endcase
    m_trig_prev = trigger;
    m_lfsr = nxt;
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("m_dout", dout, exp_dout());
        chk("m_cmd_seq", cmd_seq, m_phase == P_SEQ);
        chk("m_cmd_delay", cmd_delay, m_phase == P_DELAY);
        chk("m_delay_n", delay_n, m_lfsr);
        chk("m_rt", rt, m_rt);
        chk("m_rt_valid", rt_valid, m_rtv);
        chk("m_false_start", false_start, m_fs);
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: got timeout expected finish at %0t", $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int seq_cnt;
    int del_cnt;

    // Reset and LFSR walk
    do_reset();
    chk("rst_dout", dout, 0);
    chk("rst_cmd_seq", cmd_seq, 0);
    chk("rst_cmd_delay", cmd_delay, 0);
    chk("rst_delay_n", delay_n, 1);
    chk("rst_rt", rt, 0);
    chk("rst_rt_valid", rt_valid, 0);
    chk("rst_false_start", false_start, 0);
    rst = 1'b0;
    en  = 1'b1;
    @(negedge clk); chk("lfsr_walk_1", delay_n, 2);
    @(negedge clk); chk("lfsr_walk_2", delay_n, 4);
    @(negedge clk); chk("lfsr_walk_3", delay_n, 8);
    en = 1'b0;

    // Full sequence with delay_n=1
    do_reset();
    rst = 1'b0;
    @(negedge clk);
    for (int k = 1; k <= NL; k++) exp_q.push_back(NL'((1 << k) - 1));
    pulse_trigger();
    chk("seq_entry_cmd", cmd_seq, 1);
    chk("seq_entry_dout", dout, 0);
    seq_cnt = 1;
    del_cnt = 0;
    for (int c = 2; c <= 37; c++) begin
      @(negedge clk);
      seq_cnt += int'(cmd_seq);
      del_cnt += int'(cmd_delay);
      if (((c - 1) % 4 == 0) && c <= 33) chk("seq_lamp", dout, exp_q.pop_front());
    end
    chk("seq_cycles", seq_cnt, 32);
    chk("hold_cycles", del_cnt, 4);
    chk("lights_out", dout, 0);

    // Reaction at REACT cycle 10, then a second press
    repeat (10) @(negedge clk);
    react = 1'b1;
    @(negedge clk);
    chk("rt_value", rt, REACT_EN ? 10 : 0);
    chk("rt_valid_pulse", rt_valid, REACT_EN);
    react = 1'b0;
    @(negedge clk);
    chk("rt_valid_one_cycle", rt_valid, 0);
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
    chk("second_press_no_pulse", rt_valid, 0);
    @(negedge clk);
    chk("second_press_rt_kept", rt, REACT_EN ? 10 : 0);

    // False start at dout=07
    pulse_trigger();
    repeat (12) @(negedge clk);
    chk("fs_pre_dout", dout, 8'h07);
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
    chk("fs_pulse", false_start, REACT_EN);
    chk("fs_dout", dout, REACT_EN ? 0 : 8'h07);
    chk("fs_rt_valid", rt_valid, 0);
    @(negedge clk);
    chk("fs_one_cycle", false_start, 0);
    for (int i = 0; i < 200 && (cmd_seq || cmd_delay); i++) @(negedge clk);
    chk("idle_wait", {cmd_seq, cmd_delay}, 0);
    @(negedge clk);

    // Fresh trigger held high, then re-pulsed mid-sequence
    trigger = 1'b1;
    @(negedge clk);
    chk("restart_cmd", cmd_seq, 1);
    chk("restart_dout", dout, 0);
    repeat (4) @(negedge clk);
    chk("restart_first_lamp", dout, 8'h01);
    repeat (5) @(negedge clk);
    trigger = 1'b0;
    @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("no_restart", dout, 8'h07);

    // Reset mid-DELAY
    for (int i = 0; i < 100 && !cmd_delay; i++) @(negedge clk);
    chk("reach_delay", cmd_delay, 1);
    trigger = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_cmd_delay", cmd_delay, 0);
    chk("mid_rst_cmd_seq", cmd_seq, 0);
    chk("mid_rst_delay_n", delay_n, 1);
    chk("mid_rst_rt", rt, 0);
    chk("mid_rst_rt_valid", rt_valid, 0);

    // Free-running LFSR gives a longer random hold
    @(negedge clk);
    en = 1'b1;
    pulse_trigger();
    for (int i = 0; i < 100 && !cmd_delay; i++) @(negedge clk);
    chk("rand_reach_delay", cmd_delay, 1);
    for (int i = 0; i < 1000 && cmd_delay; i++) @(negedge clk);
    chk("rand_hold_end", cmd_delay, 0);
    repeat (5) @(negedge clk);
    react = 1'b1;
    @(negedge clk);
    react = 1'b0;
    chk("rt_random_hold", rt, REACT_EN ? 5 : 0);
    en = 1'b0;
    repeat (3) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
